// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter, edge-mode
// select, one-cycle tick, sticky pending flag and saturating event counter.
module multi_edge_detector #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 3,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       level,
  input  logic [2*CH-1:0]     mode,
  input  logic [CH-1:0]       clr,
  output logic [CH-1:0]       tck,
  output logic [CH-1:0]       filt,
  output logic [CH-1:0]       pending,
  output logic [CH*CNT_W-1:0] count,
  output logic [CH-1:0]       ovf
);

  localparam int FW = $clog2(FILTER + 1);
  localparam logic [FW-1:0]    F_LAST  = FW'(FILTER - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CAND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    CAND_LO   = 2'd3
  } state_t;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   rise_en;
    logic                   fall_en;
    state_t                 st;
    logic [FW-1:0]          fcnt;
    logic                   filt_r;
    logic                   tck_r;
    logic                   pend_r;
    logic                   ovf_r;
    logic [CNT_W-1:0]       cnt_r;

    assign s       = sync[SYNC_STAGES-1];
    assign rise_en = mode[2*i];
    assign fall_en = mode[2*i+1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], level[i]};
    end

    // fcnt counts consecutive samples of the candidate level; commit on the FILTER-th
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st     <= STABLE_LO;
        fcnt   <= '0;
        filt_r <= 1'b0;
        tck_r  <= 1'b0;
      end else begin
        tck_r <= 1'b0;
        unique case (st)
          STABLE_LO: if (s) begin
            if (FILTER == 1) begin
              st     <= STABLE_HI;
              filt_r <= 1'b1;
              tck_r  <= rise_en;
            end else begin
              st   <= CAND_HI;
              fcnt <= FW'(1);
            end
          end
          CAND_HI: begin
            if (!s) begin
              st   <= STABLE_LO;
              fcnt <= '0;
            end else if (fcnt == F_LAST) begin
              st     <= STABLE_HI;
              fcnt   <= '0;
              filt_r <= 1'b1;
              tck_r  <= rise_en;
            end else begin
              fcnt <= fcnt + FW'(1);
            end
          end
          STABLE_HI: if (!s) begin
            if (FILTER == 1) begin
              st     <= STABLE_LO;
              filt_r <= 1'b0;
              tck_r  <= fall_en;
            end else begin
              st   <= CAND_LO;
              fcnt <= FW'(1);
            end
          end
          CAND_LO: begin
            if (s) begin
              st   <= STABLE_HI;
              fcnt <= '0;
            end else if (fcnt == F_LAST) begin
              st     <= STABLE_LO;
              fcnt   <= '0;
              filt_r <= 1'b0;
              tck_r  <= fall_en;
            end else begin
              fcnt <= fcnt + FW'(1);
            end
          end
          default: begin
            st   <= STABLE_LO;
            fcnt <= '0;
          end
        endcase
      end
    end

    // A tick arriving with clr wins over the clear: the event itself is counted
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_r <= 1'b0;
        cnt_r  <= '0;
        ovf_r  <= 1'b0;
      end else begin
        if (tck_r)       pend_r <= 1'b1;
        else if (clr[i]) pend_r <= 1'b0;

        if (tck_r) begin
          if (clr[i]) begin
            cnt_r <= CNT_W'(1);
            ovf_r <= 1'b0;
          end else if (cnt_r == CNT_MAX) begin
            ovf_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end else if (clr[i]) begin
          cnt_r <= '0;
          ovf_r <= 1'b0;
        end
      end
    end

    assign tck[i]                   = tck_r;
    assign filt[i]                  = filt_r;
    assign pending[i]               = pend_r;
    assign ovf[i]                   = ovf_r;
    assign count[i*CNT_W +: CNT_W]  = cnt_r;
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: default instance plus a CNT_W=2 instance on shared
// inputs, checked every cycle against a sample-window reference model.
module tb_multi_edge_detector;
  localparam int CH = 4;
  localparam int SS = 2;
  localparam int F  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] level;
  logic [2*CH-1:0] mode;
  logic [CH-1:0] clr;

  logic [CH-1:0]   tck, filt, pending, ovf;
  logic [CH*8-1:0] count;
  logic [CH-1:0]   tck_s, filt_s, pending_s, ovf_s;
  logic [CH*2-1:0] count_s;

  int vectors = 0;
  int errs    = 0;

  multi_edge_detector #(.CH(CH), .SYNC_STAGES(SS), .FILTER(F), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .level(level), .mode(mode), .clr(clr),
    .tck(tck), .filt(filt), .pending(pending), .count(count), .ovf(ovf));

  multi_edge_detector #(.CH(CH), .SYNC_STAGES(SS), .FILTER(F), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .level(level), .mode(mode), .clr(clr),
    .tck(tck_s), .filt(filt_s), .pending(pending_s), .count(count_s), .ovf(ovf_s));

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last F synchronised samples all
  // differ from the accepted level; the synchronised sample at edge n is the raw
  // level seen at edge n-SS (zero before reset release).
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_tck, m_filt, m_pend, m_ovf, m_ovfs;
  int            m_cnt[CH];
  int            m_cnts[CH];

  function automatic logic s_at(int n, int c);
    if (n - SS < 0) return 1'b0;
    return hist[n-SS][c];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      m_tck = '0; m_filt = '0; m_pend = '0; m_ovf = '0; m_ovfs = '0;
      for (int c = 0; c < CH; c++) begin
        m_cnt[c] = 0;
        m_cnts[c] = 0;
      end
    end else begin
      int  n;
      logic commit;
      hist.push_back(level);
      n = hist.size() - 1;
      for (int c = 0; c < CH; c++) begin
        commit = 1'b1;
        for (int k = 0; k < F; k++)
          if (s_at(n - k, c) == m_filt[c]) commit = 1'b0;

        if (m_tck[c]) m_pend[c] = 1'b1;
        else if (clr[c]) m_pend[c] = 1'b0;

        if (m_tck[c]) begin
          if (clr[c]) begin
            m_cnt[c] = 1; m_ovf[c] = 1'b0;
            m_cnts[c] = 1; m_ovfs[c] = 1'b0;
          end else begin
            if (m_cnt[c] == 255) m_ovf[c] = 1'b1; else m_cnt[c]++;
            if (m_cnts[c] == 3) m_ovfs[c] = 1'b1; else m_cnts[c]++;
          end
        end else if (clr[c]) begin
          m_cnt[c] = 0; m_ovf[c] = 1'b0;
          m_cnts[c] = 0; m_ovfs[c] = 1'b0;
        end

        m_tck[c] = commit && (m_filt[c] ? mode[2*c+1] : mode[2*c]);
        if (commit) m_filt[c] = ~m_filt[c];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [CH*8-1:0] ec;
    logic [CH*2-1:0] ecs;
    for (int c = 0; c < CH; c++) begin
      ec[c*8 +: 8]  = 8'(m_cnt[c]);
      ecs[c*2 +: 2] = 2'(m_cnts[c]);
    end
    chk("tck", 64'(tck), 64'(m_tck));
    chk("filt", 64'(filt), 64'(m_filt));
    chk("pending", 64'(pending), 64'(m_pend));
    chk("count", 64'(count), 64'(ec));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("tck_s", 64'(tck_s), 64'(m_tck));
    chk("pending_s", 64'(pending_s), 64'(m_pend));
    chk("count_s", 64'(count_s), 64'(ecs));
    chk("ovf_s", 64'(ovf_s), 64'(m_ovfs));
  endtask

  task automatic step(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tck"}, 64'(tck), 64'(0));
    chk({tag, "_filt"}, 64'(filt), 64'(0));
    chk({tag, "_pending"}, 64'(pending), 64'(0));
    chk({tag, "_count"}, 64'(count), 64'(0));
    chk({tag, "_ovf"}, 64'(ovf), 64'(0));
    chk({tag, "_count_s"}, 64'(count_s), 64'(0));
    chk({tag, "_ovf_s"}, 64'(ovf_s), 64'(0));
  endtask

  logic [1:0] sweep_mode[4];
  int         sweep_exp[4];

  initial begin
    int  pulses, first, last;
    bit  saw_filt, seen;

    sweep_mode = '{2'b01, 2'b10, 2'b11, 2'b00};
    sweep_exp  = '{1, 1, 2, 0};

    rst = 1'b1; level = '0; mode = '0; clr = '0;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ch0 rising, mode 01: commit on edge 5
    mode[1:0] = 2'b01;
    level[0]  = 1'b1;
    step(4);
    chk("lat_filt_pre", 64'(filt[0]), 64'(0));
    step(1);
    chk("lat_filt", 64'(filt[0]), 64'(1));
    chk("lat_tck", 64'(tck[0]), 64'(1));
    step(1);
    chk("lat_tck_off", 64'(tck[0]), 64'(0));
    chk("lat_pending", 64'(pending[0]), 64'(1));
    chk("lat_count", 64'(count[7:0]), 64'(1));

    // ch1 glitch rejection then a real edge
    mode[3:2] = 2'b11;
    level[1]  = 1'b1;
    step(2);
    level[1]  = 1'b0;
    step(8);
    chk("glitch_pending", 64'(pending[1]), 64'(0));
    chk("glitch_filt", 64'(filt[1]), 64'(0));
    level[1] = 1'b1;
    step(8);
    chk("hold_count", 64'(count[15:8]), 64'(1));
    chk("hold_filt", 64'(filt[1]), 64'(1));

    // ch2 mode sweep over a 10-cycle pulse
    for (int m = 0; m < 4; m++) begin
      mode[5:4] = sweep_mode[m];
      pulses = 0; first = -1; last = -1; saw_filt = 1'b0;
      level[2] = 1'b1;
      for (int t = 0; t < 22; t++) begin
        step(1);
        if (tck[2]) begin
          pulses++;
          if (first < 0) first = t;
          last = t;
        end
        if (filt[2]) saw_filt = 1'b1;
        if (t == 9) level[2] = 1'b0;
      end
      chk("sweep_pulses", 64'(pulses), 64'(sweep_exp[m]));
      if (m == 2) chk("sweep_gap", 64'(last - first), 64'(10));
      if (m == 3) chk("sweep_filt_mode0", 64'(saw_filt), 64'(1));
    end

    // ch3 saturation with the CNT_W=2 instance
    mode[7:6] = 2'b11;
    for (int k = 0; k < 5; k++) begin
      level[3] = ~level[3];
      step(8);
    end
    chk("sat_count", 64'(count_s[7:6]), 64'(3));
    chk("sat_ovf", 64'(ovf_s[3]), 64'(1));
    chk("sat_count_wide", 64'(count[31:24]), 64'(5));
    level[3] = ~level[3];
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      step(1);
      seen = tck[3];
    end
    chk("sat_tck6", 64'(seen), 64'(1));
    clr[3] = 1'b1;
    step(1);
    clr[3] = 1'b0;
    chk("sat_clr_count", 64'(count_s[7:6]), 64'(1));
    chk("sat_clr_ovf", 64'(ovf_s[3]), 64'(0));
    chk("sat_clr_pending", 64'(pending_s[3]), 64'(1));
    step(2);

    // async reset while ch0 is in a rising candidate with pending=1, count=2
    mode[1:0] = 2'b11;
    level[0]  = 1'b0;
    step(8);
    chk("pre_rst_count", 64'(count[7:0]), 64'(2));
    level[0] = 1'b1;
    step(3);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    step(2);
    rst = 1'b0;
    step(4);
    chk("post_rst_tck_pre", 64'(tck[0]), 64'(0));
    step(1);
    chk("post_rst_tck", 64'(tck[0]), 64'(1));
    step(3);

    // simultaneous edges on all channels, mixed modes
    mode  = 8'b11_01_01_11;
    level = ~level;
    step(5);
    chk("simul_tck", 64'(tck), 64'(4'b1101));
    step(3);

    // randomized traffic
    for (int t = 0; t < 600; t++) begin
      if (t % 50 == 0) mode = 8'($urandom);
      for (int c = 0; c < CH; c++)
        if ($urandom_range(5) == 0) level[c] = ~level[c];
      clr = '0;
      for (int c = 0; c < CH; c++)
        if ($urandom_range(9) == 0) clr[c] = 1'b1;
      step(1);
    end
    clr = '0;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
